div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the calculator's signed division path. Accepts one sign-magnitude operand pair over a valid/ready handshake and runs a restoring divider, one magnitude bit per cycle, through a single shared subtract/compare step. Returns both quotient and remainder, in the same 5-bit sign-magnitude result format as the combinational remainder unit, plus a divide-by-zero flag. Sits between the operand/opcode decode stage and the result mux.

## Interface
- MAG_W, default 2 — operand magnitude bits; operand width is MAG_W+1 (bit MAG_W is the sign), result width OUT_W = 2*MAG_W+1.
- clk  in  1  — single clock, rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- in_valid  in  1  — operand pair a/b present.
- in_ready  out  1  — block can accept; high only in IDLE.
- a  in  MAG_W+1  — dividend, sign-magnitude.
- b  in  MAG_W+1  — divisor, sign-magnitude.
- out_valid  out  1  — quot/rem/divbyzeroflag valid.
- out_ready  in  1  — consumer accepts result.
- quot  out  OUT_W  — {sign, zero-extended magnitude}.
- rem  out  OUT_W  — {sign, zero-extended magnitude}.
- divbyzeroflag  out  1  — b magnitude was zero.
- busy  out  1  — high in any state except IDLE.

## Operation
- FSM states: IDLE, CHECK, DIV, DONE.
- IDLE: in_ready=1. On in_valid, register a, b, clear the iteration counter and partial remainder, then go to CHECK.
- CHECK: if |b|==0, set divbyzeroflag=1, force quot=0 and rem=0, and go to DONE. Otherwise go to DIV.
- DIV: one restoring step per cycle, MSB first.
  - Shift the next dividend magnitude bit into the partial remainder (MAG_W+1 bits).
  - If partial >= |b|, subtract |b| and shift 1 into the quotient; else shift 0.
  - After MAG_W steps, go to DONE.
- DONE: out_valid=1. On out_ready, return to IDLE.
- Sign rules:
  - Quotient sign = a_sign XOR b_sign.
  - Remainder sign = a_sign.
  - Any zero magnitude forces its sign bit to 0; no negative zero is ever output. In particular, |b|==1 or |a|==|b| gives rem=0 (all bits).
- Magnitudes are zero-extended into bits [OUT_W-2:0].
- An a input with negative-zero encoding (sign=1, mag=0) is treated as +0.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, quot=0, rem=0, divbyzeroflag=0, all internal registers 0.
- Acceptance occurs at the edge where in_valid && in_ready.
- Normal latency: out_valid rises MAG_W+2 cycles after the accept edge (4 cycles at default).
- Divide-by-zero latency: out_valid rises 2 cycles after the accept edge.
- quot, rem and divbyzeroflag are registered. They change only on entry to DONE and stay stable while out_valid && !out_ready.
- There is no overlap between jobs. in_ready rises the cycle after the out_ready handshake, so minimum spacing between jobs is MAG_W+3 cycles.
- in_valid while not in IDLE is ignored; the operand registers are untouched.
- out_ready outside DONE is ignored.
- Asserting rst_n low in any state aborts immediately to reset values; no partial result is ever emitted.

## Structure
- Shared package calc_pkg holds:
  - The FSM state enum (IDLE/CHECK/DIV/DONE).
  - Sign-magnitude helpers: sign/mag field extraction and the zero-sign normalisation.
  - The MAG_W default and the OUT_W derivation.
- One sub-module, div_step: combinational single restoring step. Inputs are partial remainder, next dividend bit and divisor magnitude; outputs are the next partial remainder and the quotient bit.
- Controller, counter and output registers live in div_sequencer.

## Test plan
- Basic divide: a=011 (+3), b=010 (+2) -> quot=00001, rem=00001, flag=0, out_valid exactly 4 cycles after accept.
- Negative dividend: a=111 (-3), b=010 (+2) -> quot=10001, rem=10001. Then a=011, b=111 (-3) -> quot=10001, rem=00000 (no negative zero).
- Divide by zero: a=110, b=000 -> flag=1, quot=00000, rem=00000, out_valid 2 cycles after accept. Then a=011, b=100 (-0) -> same result.
- Unit divisor: a=011, b=101 (-1) -> quot=10011, rem=00000. Exhaustive sweep of a,b over −3..+3 matches the sign/magnitude rules above.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and an in_valid pulse is ignored. Release -> in_ready=1 on the next cycle.
- Reset mid-DIV: drop rst_n during the first DIV cycle -> all outputs at reset values immediately. After release, a new job a=010, b=011 -> quot=00000, rem=00010.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states, widths and sign-magnitude helpers for the calculator datapath
package calc_pkg;
  localparam int MAG_W_DEF = 2;
  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;
  function automatic int out_w(input int mag_w);
    return 2 * mag_w + 1;
  endfunction
  function automatic logic nz_sign(input logic s, input logic mag_zero);
    return s & ~mag_zero;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift in a bit, conditionally subtract)
module div_step
  import calc_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic [MAG_W:0]   i_part,
  input  logic             i_bit,
  input  logic [MAG_W-1:0] i_div,
  output logic [MAG_W:0]   o_part,
  output logic             o_qbit
);
  logic [MAG_W:0] w_sh;
  assign w_sh   = {i_part[MAG_W-1:0], i_bit};
  assign o_qbit = i_part[MAG_W] | (w_sh >= {1'b0, i_div});
  assign o_part = o_qbit ? w_sh - {1'b0, i_div} : w_sh;
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle sign-magnitude restoring divider with valid/ready handshake
module div_sequencer
  import calc_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF,
  localparam int OUT_W = out_w(MAG_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   a,
  input  logic [MAG_W:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] quot,
  output logic [OUT_W-1:0] rem,
  output logic             divbyzeroflag,
  output logic             busy
);
  localparam int CW = $clog2(MAG_W + 1);
  typedef logic [MAG_W-1:0] mag_t;
  typedef logic [CW-1:0] cnt_t;
  state_t         r_state;
  logic           r_a_s, r_b_s, r_dbz;
  mag_t           r_b_mag, r_dvd, r_q;
  logic [MAG_W:0] r_part;
  cnt_t           r_cnt;
  logic [OUT_W-1:0] r_quot, r_rem;
  logic [MAG_W:0] w_part_next;
  logic           w_qbit;
  mag_t           w_q_next, w_dvd_next, w_rem_mag;
  logic           w_last;
  div_step #(.MAG_W(MAG_W)) u_step (
    .i_part(r_part),
    .i_bit (r_dvd[MAG_W-1]),
    .i_div (r_b_mag),
    .o_part(w_part_next),
    .o_qbit(w_qbit)
  );
  assign w_q_next   = mag_t'({r_q, w_qbit});
  assign w_dvd_next = mag_t'({r_dvd, 1'b0});
  assign w_rem_mag  = w_part_next[MAG_W-1:0];
  assign w_last     = r_cnt == cnt_t'(MAG_W - 1);
  assign in_ready      = r_state == IDLE;
  assign busy          = r_state != IDLE;
  assign out_valid     = r_state == DONE;
  assign quot          = r_quot;
  assign rem           = r_rem;
  assign divbyzeroflag = r_dbz;
  // Controller: accept, zero-check, MSB-first iteration, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_s   <= 1'b0;
      r_b_s   <= 1'b0;
      r_b_mag <= '0;
      r_dvd   <= '0;
      r_q     <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a_s   <= a[MAG_W] & |a[MAG_W-1:0];
          r_b_s   <= b[MAG_W];
          r_b_mag <= b[MAG_W-1:0];
          r_dvd   <= a[MAG_W-1:0];
          r_q     <= '0;
          r_part  <= '0;
          r_cnt   <= '0;
          r_state <= CHECK;
        end
        CHECK: if (r_b_mag == '0) begin
          r_dbz   <= 1'b1;
          r_quot  <= '0;
          r_rem   <= '0;
          r_state <= DONE;
        end else begin
          r_state <= DIV;
        end
        DIV: begin
          r_part <= w_part_next;
          r_q    <= w_q_next;
          r_dvd  <= w_dvd_next;
          r_cnt  <= cnt_t'(r_cnt + 1'b1);
          if (w_last) begin
            r_dbz   <= 1'b0;
            r_quot  <= {nz_sign(r_a_s ^ r_b_s, w_q_next == '0), {MAG_W{1'b0}}, w_q_next};
            r_rem   <= {nz_sign(r_a_s, w_rem_mag == '0), {MAG_W{1'b0}}, w_rem_mag};
            r_state <= DONE;
          end
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vector table, sign-rule sweep and multi-cycle corner sequences
module tb_div_sequencer;
  localparam int MW = 2;
  localparam int OW = 2 * MW + 1;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [MW:0] a = '0, b = '0;
  logic in_ready, out_valid, divbyzeroflag, busy;
  logic [OW-1:0] quot, rem;
  int total = 0, bad = 0;
  typedef struct {
    logic [MW:0]   a, b;
    logic [OW-1:0] q, r;
    logic          f;
    int            lat;
  } vec_t;
  vec_t tv[10];
  always #5 clk = ~clk;
  div_sequencer #(.MAG_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .divbyzeroflag(divbyzeroflag), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [MW:0] va, input logic [MW:0] vb);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", 32'(in_ready), 1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL out_valid_timeout: got 0 want 1 within 20 cycles");
    end
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  function automatic logic [MW:0] enc(input int v);
    int m = v < 0 ? -v : v;
    return {v < 0, m[MW-1:0]};
  endfunction
  initial begin
    int cyc, am, bm, qm, rm;
    logic [OW-1:0] eq, er, q0, r0;
    tv[0] = '{3'b011, 3'b010, 5'b00001, 5'b00001, 1'b0, 4};
    tv[1] = '{3'b111, 3'b010, 5'b10001, 5'b10001, 1'b0, 4};
    tv[2] = '{3'b011, 3'b111, 5'b10001, 5'b00000, 1'b0, 4};
    tv[3] = '{3'b110, 3'b000, 5'b00000, 5'b00000, 1'b1, 2};
    tv[4] = '{3'b011, 3'b100, 5'b00000, 5'b00000, 1'b1, 2};
    tv[5] = '{3'b011, 3'b101, 5'b10011, 5'b00000, 1'b0, 4};
    tv[6] = '{3'b010, 3'b011, 5'b00000, 5'b00010, 1'b0, 4};
    tv[7] = '{3'b100, 3'b011, 5'b00000, 5'b00000, 1'b0, 4};
    tv[8] = '{3'b101, 3'b110, 5'b00000, 5'b10001, 1'b0, 4};
    tv[9] = '{3'b110, 3'b001, 5'b10010, 5'b00000, 1'b0, 4};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_quot", 32'(quot), 0);
    chk("rst_rem", 32'(rem), 0);
    chk("rst_flag", 32'(divbyzeroflag), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tv[i].a, tv[i].b);
      chk("busy_in_job", 32'(busy), 1);
      chk("ready_in_job", 32'(in_ready), 0);
      wait_out(cyc);
      chk("vec_latency", cyc, tv[i].lat);
      chk("vec_quot", 32'(quot), 32'(tv[i].q));
      chk("vec_rem", 32'(rem), 32'(tv[i].r));
      chk("vec_flag", 32'(divbyzeroflag), 32'(tv[i].f));
      release_out();
    end
    for (int x = -3; x <= 3; x++) begin
      for (int y = -3; y <= 3; y++) begin
        am = x < 0 ? -x : x;
        bm = y < 0 ? -y : y;
        qm = bm == 0 ? 0 : am / bm;
        rm = bm == 0 ? 0 : am % bm;
        eq = {(x < 0) != (y < 0) && qm != 0, 2'b00, 2'(qm)};
        er = {x < 0 && rm != 0, 2'b00, 2'(rm)};
        send(enc(x), enc(y));
        wait_out(cyc);
        chk("sweep_latency", cyc, bm == 0 ? 2 : 4);
        chk("sweep_result", {21'b0, quot, rem, divbyzeroflag}, {21'b0, eq, er, bm == 0});
        release_out();
      end
    end
    send(3'b011, 3'b010);
    wait_out(cyc);
    q0 = quot;
    r0 = rem;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_quot", 32'(quot), 32'(q0));
      chk("bp_rem", 32'(rem), 32'(r0));
      if (i == 1) begin
        a = 3'b010;
        b = 3'b001;
        in_valid = 1'b1;
      end
    end
    chk("bp_quot_value", 32'(q0), 32'(5'b00001));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 1);
    chk("bp_release_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("bp_no_ghost_job", 32'(busy), 0);
    send(3'b011, 3'b010);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_quot", 32'(quot), 0);
    chk("mid_rst_rem", 32'(rem), 0);
    chk("mid_rst_flag", 32'(divbyzeroflag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'b010, 3'b011);
    wait_out(cyc);
    chk("post_rst_latency", cyc, 4);
    chk("post_rst_quot", 32'(quot), 32'(5'b00000));
    chk("post_rst_rem", 32'(rem), 32'(5'b00010));
    chk("post_rst_flag", 32'(divbyzeroflag), 0);
    release_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
